// File: rtl/mem_lsu.sv
// Load/store unit for the MEM stage: formats stores, extracts loads, and runs a
// single-outstanding IDLE/REQ/DONE handshake against the data memory.
module mem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic [31:0] ld_data,
    output logic        stall,
    output logic        misalign
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_reg;
    logic        we_reg;
    logic [2:0]  funct3_reg;
    logic [1:0]  off_reg;
    logic        dm_req_reg;
    logic        dm_we_reg;
    logic [31:0] dm_addr_reg;
    logic [31:0] dm_wdata_reg;
    logic [3:0]  dm_be_reg;
    logic [31:0] ld_data_reg;
    logic        misalign_reg;

    logic        legal;
    logic        aligned;
    logic        accept;
    logic [3:0]  be_sb;
    logic [31:0] wdata_sb;
    logic [31:0] wdata_sh;
    logic [7:0]  rd_byte [4];
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_next;

    // BU/HU only exist as loads; 011/110/111 are unused encodings.
    always_comb begin
        legal = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !req_we;
            default:                legal = 1'b0;
        endcase
        aligned = 1'b1;
        case (funct3[1:0])
            2'b01:   aligned = !addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    assign accept = (state_reg == IDLE) && req_valid && legal && aligned;
    assign stall  = !rst && (accept || (state_reg == REQ));

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign be_sb[gi]             = (addr[1:0] == 2'(gi));
            assign wdata_sb[8*gi +: 8]   = st_data[7:0];
            assign wdata_sh[8*gi +: 8]   = st_data[8*(gi%2) +: 8];
            assign rd_byte[gi]           = dm_rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = st_data;
        if (req_we) begin
            case (funct3[1:0])
                2'b00: begin
                    be_next    = be_sb;
                    wdata_next = wdata_sb;
                end
                2'b01: begin
                    be_next    = addr[1] ? 4'b1100 : 4'b0011;
                    wdata_next = wdata_sh;
                end
                default: begin
                    be_next    = 4'b1111;
                    wdata_next = st_data;
                end
            endcase
        end
    end

    // Lane selection uses the offset captured at accept, not the live address.
    always_comb begin
        byte_sel = rd_byte[off_reg];
        half_sel = off_reg[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (funct3_reg)
            3'b000:  ld_next = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  ld_next = {{16{half_sel[15]}}, half_sel};
            3'b100:  ld_next = {24'h0, byte_sel};
            3'b101:  ld_next = {16'h0, half_sel};
            default: ld_next = dm_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            we_reg       <= 1'b0;
            funct3_reg   <= 3'b000;
            off_reg      <= 2'b00;
            dm_req_reg   <= 1'b0;
            dm_we_reg    <= 1'b0;
            dm_addr_reg  <= 32'h0;
            dm_wdata_reg <= 32'h0;
            dm_be_reg    <= 4'h0;
            ld_data_reg  <= 32'h0;
            misalign_reg <= 1'b0;
        end else begin
            misalign_reg <= (state_reg == IDLE) && req_valid && !(legal && aligned);
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        we_reg       <= req_we;
                        funct3_reg   <= funct3;
                        off_reg      <= addr[1:0];
                        dm_req_reg   <= 1'b1;
                        dm_we_reg    <= req_we;
                        dm_addr_reg  <= {addr[31:2], 2'b00};
                        dm_wdata_reg <= wdata_next;
                        dm_be_reg    <= be_next;
                        state_reg    <= REQ;
                    end
                end
                REQ: begin
                    if (dm_ack) begin
                        dm_req_reg <= 1'b0;
                        state_reg  <= DONE;
                        if (!we_reg) begin
                            ld_data_reg <= ld_next;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign dm_req   = dm_req_reg;
    assign dm_we    = dm_we_reg;
    assign dm_addr  = dm_addr_reg;
    assign dm_wdata = dm_wdata_reg;
    assign dm_be    = dm_be_reg;
    assign ld_data  = ld_data_reg;
    assign misalign = misalign_reg;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: loads, stores, misaligned/illegal accesses,
// delayed acknowledge and reset during an outstanding request.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic [31:0] ld_data;
    logic        stall;
    logic        misalign;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_ld = 32'h0;

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_we   (req_we),
        .funct3   (funct3),
        .addr     (addr),
        .st_data  (st_data),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_be    (dm_be),
        .dm_ack   (dm_ack),
        .dm_rdata (dm_rdata),
        .ld_data  (ld_data),
        .stall    (stall),
        .misalign (misalign)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Full legal access; ack arrives after 'delay' wait cycles in REQ and is
    // then held into DONE with different data, which must be ignored.
    task automatic access(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input int delay,
                          input logic [31:0] rd, input logic [31:0] exp_ld,
                          input logic [31:0] exp_wdata, input logic [3:0] exp_be);
        int          req_cycles;
        int          stall_cycles;
        logic [31:0] want_ld;
        logic [31:0] want_addr;
        want_ld   = we ? last_ld : exp_ld;
        want_addr = {a[31:2], 2'b00};
        req_valid = 1'b1;
        req_we    = we;
        funct3    = f3;
        addr      = a;
        st_data   = sd;
        #1;
        check({tag, " stall_idle"}, 32'(stall), 32'd1);
        stall_cycles = stall ? 1 : 0;
        req_cycles   = 0;
        @(posedge clk); #1;
        check({tag, " dm_we"}, 32'(dm_we), 32'(we));
        check({tag, " dm_be"}, 32'(dm_be), 32'(exp_be));
        if (we) check({tag, " dm_wdata"}, dm_wdata, exp_wdata);
        for (int i = 0; i <= delay; i++) begin
            if (i == delay) begin
                dm_ack   = 1'b1;
                dm_rdata = rd;
                #1;
            end
            if (dm_req) req_cycles++;
            if (stall) stall_cycles++;
            check({tag, " dm_addr_hold"}, dm_addr, want_addr);
            @(posedge clk); #1;
        end
        dm_rdata = 32'h5A5A_A5A5;
        check({tag, " req_cycles"}, 32'(req_cycles), 32'(delay + 1));
        check({tag, " stall_cycles"}, 32'(stall_cycles), 32'(delay + 2));
        check({tag, " done_req"}, 32'(dm_req), 32'd0);
        check({tag, " done_stall"}, 32'(stall), 32'd0);
        check({tag, " ld_data"}, ld_data, want_ld);
        req_valid = 1'b0;
        @(posedge clk); #1;
        dm_ack = 1'b0;
        check({tag, " idle_req"}, 32'(dm_req), 32'd0);
        check({tag, " ld_keep"}, ld_data, want_ld);
        last_ld = want_ld;
        $display("TXN %s addr=%h we=%0d f3=%b ld_data=%h be=%b wdata=%h",
                 tag, a, we, f3, ld_data, dm_be, dm_wdata);
    endtask

    task automatic bad_access(input string tag, input logic we, input logic [2:0] f3,
                              input logic [31:0] a);
        req_valid = 1'b1;
        req_we    = we;
        funct3    = f3;
        addr      = a;
        st_data   = 32'hFFFF_FFFF;
        #1;
        check({tag, " stall"}, 32'(stall), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({tag, " misalign"}, 32'(misalign), 32'd1);
        check({tag, " no_req"}, 32'(dm_req), 32'd0);
        check({tag, " ld_keep"}, ld_data, last_ld);
        @(posedge clk); #1;
        check({tag, " misalign_end"}, 32'(misalign), 32'd0);
        check({tag, " no_req2"}, 32'(dm_req), 32'd0);
        $display("TXN %s addr=%h we=%0d f3=%b misalign pulse", tag, a, we, f3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        funct3    = 3'b010;
        addr      = 32'h100;
        st_data   = 32'h0;
        dm_ack    = 1'b0;
        dm_rdata  = 32'h0;
        @(posedge clk); @(posedge clk); #1;
        check("rst dm_req", 32'(dm_req), 32'd0);
        check("rst dm_we", 32'(dm_we), 32'd0);
        check("rst dm_addr", dm_addr, 32'h0);
        check("rst dm_wdata", dm_wdata, 32'h0);
        check("rst dm_be", 32'(dm_be), 32'h0);
        check("rst ld_data", ld_data, 32'h0);
        check("rst misalign", 32'(misalign), 32'd0);
        check("rst stall", 32'(stall), 32'd0);
        req_valid = 1'b0;
        rst       = 1'b0;
        @(posedge clk); #1;

        access("LW",   1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 4'hF);
        access("LB",   1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_1234, 32'hFFFF_FF80, 32'h0, 4'hF);
        access("LBU",  1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF_1234, 32'h0000_0080, 32'h0, 4'hF);
        access("LHU",  1'b0, 3'b101, 32'h102, 32'h0, 0, 32'h80FF_1234, 32'h0000_80FF, 32'h0, 4'hF);
        access("LH",   1'b0, 3'b001, 32'h102, 32'h0, 0, 32'h80FF_1234, 32'hFFFF_80FF, 32'h0, 4'hF);
        access("LBU1", 1'b0, 3'b100, 32'h101, 32'h0, 0, 32'h80FF_1234, 32'h0000_0012, 32'h0, 4'hF);
        access("LB0",  1'b0, 3'b000, 32'h100, 32'h0, 0, 32'h80FF_1234, 32'h0000_0034, 32'h0, 4'hF);
        access("SB",   1'b1, 3'b000, 32'h201, 32'h0000_00AB, 0, 32'h0, 32'h0, 32'hABAB_ABAB, 4'b0010);
        access("SH",   1'b1, 3'b001, 32'h202, 32'h0000_1234, 0, 32'h0, 32'h0, 32'h1234_1234, 4'b1100);
        access("SHlo", 1'b1, 3'b001, 32'h200, 32'hFFFF_5678, 2, 32'h0, 32'h0, 32'h5678_5678, 4'b0011);
        access("SW",   1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 0, 32'h0, 32'h0, 32'hCAFE_F00D, 4'hF);
        access("LWd5", 1'b0, 3'b010, 32'h100, 32'h0, 5, 32'h0123_4567, 32'h0123_4567, 32'h0, 4'hF);

        bad_access("LWmis",  1'b0, 3'b010, 32'h102);
        bad_access("F011",   1'b0, 3'b011, 32'h100);
        bad_access("SHmis",  1'b1, 3'b001, 32'h201);
        bad_access("SBU",    1'b1, 3'b100, 32'h100);
        bad_access("LHmis",  1'b0, 3'b001, 32'h103);

        // Reset in the third REQ cycle abandons the load; a late ack is ignored.
        req_valid = 1'b1;
        req_we    = 1'b0;
        funct3    = 3'b010;
        addr      = 32'h100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rstreq dm_req_before", 32'(dm_req), 32'd1);
        rst = 1'b1;
        #1;
        check("rstreq stall", 32'(stall), 32'd0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstreq dm_req", 32'(dm_req), 32'd0);
        check("rstreq ld_data", ld_data, 32'h0);
        dm_ack   = 1'b1;
        dm_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dm_ack = 1'b0;
        check("rstreq late_ack_req", 32'(dm_req), 32'd0);
        check("rstreq late_ack_ld", ld_data, 32'h0);
        check("rstreq late_ack_stall", 32'(stall), 32'd0);
        $display("TXN RSTREQ addr=%h ld_data=%h", addr, ld_data);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
